// File: rtl/quad_split_sched.sv
// Read scheduler for the four-screen split display: tracks vs/de timing,
// issues a one-hot read request to the source owning the current quadrant,
// and delays the quadrant index by the sources' read latency for the
// output mux. Error pulses are informational and never alter the schedule.
//
// Handshake: there is no back-pressure. O_rd_req is a one-cycle strobe
// that the sources must accept unconditionally, and O_sel_vld marks the
// cycle in which the matching pixel data is present at the mux.
module quad_split_sched #(
  parameter int H_ACT = 1920,
  parameter int V_ACT = 1080,
  parameter int LAT   = 6,
  parameter int CW    = 12
) (
  input  logic          I_clk,
  input  logic          I_rst_n,
  input  logic          I_vs,
  input  logic          I_hs,
  input  logic          I_de,
  input  logic          I_en,
  output logic [3:0]    O_rd_req,
  output logic [CW-1:0] O_x,
  output logic [CW-1:0] O_y,
  output logic [1:0]    O_sel,
  output logic          O_sel_vld,
  output logic          O_frame_start,
  output logic          O_line_err,
  output logic          O_frame_err,
  output logic [1:0]    O_dbg_state
);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    RUN     = 2'd1,
    SKIP    = 2'd2
  } state_t;

  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACT);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACT);
  localparam logic [CW-1:0] H_HALF   = CW'(H_ACT / 2);
  localparam logic [CW-1:0] V_HALF   = CW'(V_ACT / 2);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t          state_q, state_d;
  logic            vs_q, de_q;
  logic [CW-1:0]   x_q, x_d, y_q, y_d;
  logic [3:0]      rd_req_q, rd_req_d;
  logic [CW-1:0]   ox_q, ox_d, oy_q, oy_d;
  logic            fs_q, fs_d, le_q, le_d, fe_q, fe_d;
  logic [1:0]      sel_q [LAT];
  logic [1:0]      sel_d [LAT];
  logic [LAT-1:0]  vld_q, vld_d;

  logic            vs_rise, de_fall, active, run_now;
  logic [CW-1:0]   cx, cy;
  logic [1:0]      quad;

  // Edge detection and the coordinates of the pixel sampled this cycle;
  // a vs edge takes priority, so a coincident de pixel is x=0,y=0.
  always_comb begin
    vs_rise = I_vs & ~vs_q;
    de_fall = ~I_de & de_q;
    active  = vs_rise | (state_q != WAIT_VS);
    run_now = vs_rise ? I_en : (state_q == RUN);
    cx      = vs_rise ? '0 : x_q;
    cy      = vs_rise ? '0 : y_q;
    quad    = {cy >= V_HALF, cx >= H_HALF};
  end

  // Next-state, counters, request generation and error flags.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    rd_req_d = '0;
    ox_d     = ox_q;
    oy_d     = oy_q;
    fs_d     = 1'b0;
    le_d     = 1'b0;
    fe_d     = 1'b0;
    if (vs_rise) begin
      fs_d    = 1'b1;
      fe_d    = (state_q != WAIT_VS) && (y_q != V_ACT_C);
      state_d = I_en ? RUN : SKIP;
      x_d     = '0;
      y_d     = '0;
    end
    if (active) begin
      if (I_de) begin
        x_d = (cx == CNT_MAX) ? cx : cx + 1'b1;
        if (run_now) begin
          rd_req_d = 4'b0001 << quad;
          ox_d     = cx;
          oy_d     = cy;
        end
      end else if (de_fall && !vs_rise) begin
        le_d = (x_q != H_ACT_C);
        x_d  = '0;
        y_d  = (y_q == CNT_MAX) ? y_q : y_q + 1'b1;
      end
    end
  end

  // Select pipeline: the registered request is re-encoded to a quadrant
  // index and delayed so it lines up with the returning pixel data.
  always_comb begin
    sel_d[0] = {rd_req_q[3] | rd_req_q[2], rd_req_q[3] | rd_req_q[1]};
    vld_d    = vld_q;
    vld_d[0] = |rd_req_q;
    for (int i = 1; i < LAT; i++) begin
      sel_d[i] = sel_q[i-1];
      vld_d[i] = vld_q[i-1];
    end
  end

  // State and datapath registers.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q  <= WAIT_VS;
      vs_q     <= 1'b0;
      de_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      rd_req_q <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      fs_q     <= 1'b0;
      le_q     <= 1'b0;
      fe_q     <= 1'b0;
      vld_q    <= '0;
      for (int i = 0; i < LAT; i++) sel_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      vs_q     <= I_vs;
      de_q     <= I_de;
      x_q      <= x_d;
      y_q      <= y_d;
      rd_req_q <= rd_req_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      fs_q     <= fs_d;
      le_q     <= le_d;
      fe_q     <= fe_d;
      vld_q    <= vld_d;
      for (int i = 0; i < LAT; i++) sel_q[i] <= sel_d[i];
    end
  end

  assign O_rd_req      = rd_req_q;
  assign O_x           = ox_q;
  assign O_y           = oy_q;
  assign O_sel         = sel_q[LAT-1];
  assign O_sel_vld     = vld_q[LAT-1];
  assign O_frame_start = fs_q;
  assign O_line_err    = le_q;
  assign O_frame_err   = fe_q;
  assign O_dbg_state   = state_q;

  // hs carries no information the scheduler needs.
  logic unused_hs;
  assign unused_hs = I_hs;

endmodule

// File: tb/tb_quad_split_sched.sv
// Directed bench for quad_split_sched with an 8x4 active frame.
module tb_quad_split_sched;

  localparam int H_ACT = 8;
  localparam int V_ACT = 4;
  localparam int LAT   = 6;
  localparam int CW    = 12;

  logic          I_clk, I_rst_n, I_vs, I_hs, I_de, I_en;
  logic [3:0]    O_rd_req;
  logic [CW-1:0] O_x, O_y;
  logic [1:0]    O_sel;
  logic          O_sel_vld, O_frame_start, O_line_err, O_frame_err;
  logic [1:0]    O_dbg_state;

  quad_split_sched #(.H_ACT(H_ACT), .V_ACT(V_ACT), .LAT(LAT), .CW(CW)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_vs(I_vs), .I_hs(I_hs), .I_de(I_de),
    .I_en(I_en), .O_rd_req(O_rd_req), .O_x(O_x), .O_y(O_y), .O_sel(O_sel),
    .O_sel_vld(O_sel_vld), .O_frame_start(O_frame_start),
    .O_line_err(O_line_err), .O_frame_err(O_frame_err),
    .O_dbg_state(O_dbg_state)
  );

  // Clock and reset
  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: expected {vld, sel} per cycle, compared LAT cycles later.
  logic [2:0] exp_q[$];

  typedef struct {
    logic       vs;
    logic       de;
    logic [3:0] req;
    int         x;
    int         y;
    logic       fs;
    logic       le;
    logic       fe;
  } vec_t;

  vec_t tbl[42];

  function automatic logic [3:0] req_of(input int x, input int y);
    logic [1:0] q;
    q = {y >= V_ACT / 2, x >= H_ACT / 2};
    return 4'b0001 << q;
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] r);
    return {r[3] | r[2], r[3] | r[1]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic flush_exp();
    exp_q.delete();
    for (int i = 0; i < LAT; i++) exp_q.push_back(3'b000);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rd_req"}, 32'(O_rd_req), 0);
    chk({tag, ".x"}, 32'(O_x), 0);
    chk({tag, ".y"}, 32'(O_y), 0);
    chk({tag, ".sel"}, 32'({O_sel_vld, O_sel}), 0);
    chk({tag, ".flags"}, 32'({O_frame_start, O_line_err, O_frame_err}), 0);
  endtask

  // Driver: apply one cycle of inputs, then check the registered response.
  task automatic tick(input logic vs, input logic de, input logic [3:0] ereq,
                      input int ex, input int ey, input logic efs,
                      input logic ele, input logic efe);
    I_vs = vs;
    I_de = de;
    @(posedge I_clk);
    #1;
    chk("rd_req", 32'(O_rd_req), 32'(ereq));
    if (ereq != 4'b0) begin
      chk("x", 32'(O_x), 32'(ex));
      chk("y", 32'(O_y), 32'(ey));
    end
    chk("frame_start", 32'(O_frame_start), 32'(efs));
    chk("line_err", 32'(O_line_err), 32'(ele));
    chk("frame_err", 32'(O_frame_err), 32'(efe));
    exp_q.push_back({|ereq, enc(ereq)});
    chk("sel", 32'({O_sel_vld, O_sel}), 32'(exp_q[exp_q.size() - 1 - LAT]));
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 4'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // One line of n de cycles followed by the falling-edge check and a gap.
  task automatic line(input int n, input int y, input bit run);
    for (int x = 0; x < n; x++)
      tick(1'b0, 1'b1, run ? req_of(x, y) : 4'b0, x, y, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 4'b0, 0, 0, 1'b0, n != H_ACT, 1'b0);
    idle();
  endtask

  task automatic vs_edge(input logic efe);
    tick(1'b1, 1'b0, 4'b0, 0, 0, 1'b1, 1'b0, efe);
    idle();
  endtask

  task automatic apply_table();
    for (int i = 0; i < 42; i++)
      tick(tbl[i].vs, tbl[i].de, tbl[i].req, tbl[i].x, tbl[i].y,
           tbl[i].fs, tbl[i].le, tbl[i].fe);
  endtask

  initial begin
    int k;
    // Nominal frame: vs pulse, gap, four full lines with two-cycle gaps.
    k = 0;
    tbl[k] = '{1'b1, 1'b0, 4'b0, 0, 0, 1'b1, 1'b0, 1'b0}; k = k + 1;
    tbl[k] = '{1'b0, 1'b0, 4'b0, 0, 0, 1'b0, 1'b0, 1'b0}; k = k + 1;
    for (int y = 0; y < V_ACT; y++) begin
      for (int x = 0; x < H_ACT; x++) begin
        tbl[k] = '{1'b0, 1'b1, req_of(x, y), x, y, 1'b0, 1'b0, 1'b0};
        k = k + 1;
      end
      tbl[k] = '{1'b0, 1'b0, 4'b0, 0, 0, 1'b0, 1'b0, 1'b0}; k = k + 1;
      tbl[k] = '{1'b0, 1'b0, 4'b0, 0, 0, 1'b0, 1'b0, 1'b0}; k = k + 1;
    end

    I_rst_n = 1'b0; I_vs = 1'b0; I_hs = 1'b0; I_de = 1'b0; I_en = 1'b1;
    repeat (2) @(posedge I_clk);
    #1;
    chk_all_zero("reset");
    chk("reset.state", 32'(O_dbg_state), 0);
    I_rst_n = 1'b1;
    flush_exp();

    // Nominal frame; its vs is the first after reset, so no frame error.
    apply_table();

    // Disabled frame; enabling mid-frame must not start requests.
    I_en = 1'b0;
    vs_edge(1'b0);
    line(H_ACT, 0, 1'b0);
    line(H_ACT, 1, 1'b0);
    I_en = 1'b1;
    line(H_ACT, 2, 1'b0);
    line(H_ACT, 3, 1'b0);

    // Short first line, following lines restart at x=0.
    vs_edge(1'b0);
    line(H_ACT - 1, 0, 1'b1);
    line(H_ACT, 1, 1'b1);
    line(H_ACT, 2, 1'b1);
    line(H_ACT, 3, 1'b1);

    // Frame of only three lines.
    vs_edge(1'b0);
    line(H_ACT, 0, 1'b1);
    line(H_ACT, 1, 1'b1);
    line(H_ACT, 2, 1'b1);

    // vs edge coincident with de: flags the short frame and the pixel
    // belongs to the new frame at x=0, y=0.
    tick(1'b1, 1'b1, 4'b0001, 0, 0, 1'b1, 1'b0, 1'b1);
    for (int x = 1; x < H_ACT; x++)
      tick(1'b0, 1'b1, req_of(x, 0), x, 0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 4'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    idle();
    line(H_ACT, 1, 1'b1);

    // Reset in the middle of line 2 with select entries in flight.
    for (int x = 0; x < 4; x++)
      tick(1'b0, 1'b1, req_of(x, 2), x, 2, 1'b0, 1'b0, 1'b0);
    #2;
    I_rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    flush_exp();
    tick(1'b0, 1'b1, 4'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    I_rst_n = 1'b1;
    for (int x = 5; x < H_ACT; x++)
      tick(1'b0, 1'b1, 4'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 4'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    idle();
    line(H_ACT, 3, 1'b0);

    // Next frame after reset is fully correct, then its closing vs.
    apply_table();
    vs_edge(1'b0);
    repeat (LAT) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_split_sched.md
# quad_split_sched

Read scheduler for the four-screen split display. It tracks the incoming video timing (vs/hs/de) and grants read access to one of four source frame buffers per pixel, according to the screen quadrant the pixel falls in. It also emits a quadrant select aligned to the sources' fixed read latency, so the downstream output mux picks the correct 24-bit pixel. It sits between the timing generator and the per-source buffers, in parallel with the sync delay line of matching depth.

## Interface
- H_ACT, 1920: active pixels per line (even).
- V_ACT, 1080: active lines per frame (even).
- LAT, 6: source read latency in cycles, from O_rd_req to pixel data valid.
- CW, 12: x/y counter width; 2^CW > max(H_ACT, V_ACT).
- I_clk  in  1  pixel clock.
- I_rst_n  in  1  asynchronous active-low reset.
- I_vs  in  1  vertical sync, active high.
- I_hs  in  1  horizontal sync, active high; informational only.
- I_de  in  1  data enable, high during active pixels.
- I_en  in  1  split-display enable; sampled only on the vs rising edge.
- O_rd_req  out  4  one-hot read enable, indexed by source 0..3.
- O_x  out  CW  column of the pixel currently requested.
- O_y  out  CW  row of the pixel currently requested.
- O_sel  out  2  quadrant index for the output mux.
- O_sel_vld  out  1  O_sel qualifies pixel data this cycle.
- O_frame_start  out  1  one-cycle pulse on an accepted vs rising edge.
- O_line_err  out  1  one-cycle pulse when a line length differs from H_ACT.
- O_frame_err  out  1  one-cycle pulse when a frame's line count differs from V_ACT.

## Operation
- **Edge detection.** One register each for vs and de; the rising/falling edge is detected by comparing the current input with the registered copy.
- **WAIT_VS state.** Entered on reset. All de activity is ignored. On a vs rising edge: go to RUN if I_en=1, else SKIP. O_frame_start pulses in either case. No O_frame_err is raised on this first edge.
- **RUN state.** Pixel counting and request generation are active. On a vs rising edge: check the line count, reset counters, and go to RUN or SKIP according to I_en.
- **SKIP state.** Counters run, so error checks still apply. O_rd_req and O_sel_vld stay 0. On a vs rising edge, re-evaluate I_en as above.
- **x counter.** Increments on each de-high cycle and returns to 0 on the de falling edge. Saturates at 2^CW-1.
- **y counter.** Increments on each de falling edge. Returns to 0 on the vs rising edge. Saturates at 2^CW-1.
- **Line check.** At the de falling edge, x != H_ACT pulses O_line_err.
- **Frame check.** At the vs rising edge (not the first after reset), y != V_ACT pulses O_frame_err.
- **Quadrant.** q = {y >= V_ACT/2, x >= H_ACT/2}: 0 is top-left, 1 top-right, 2 bottom-left, 3 bottom-right. The x and y values used are those before the increment for the current pixel.
- **Request.** In RUN with I_de=1, O_rd_req[q] = 1 and all other bits 0. O_x and O_y carry that pixel's coordinates.
- **Select pipeline.** q and the request-valid bit go through a LAT-stage shift register to O_sel and O_sel_vld.
- **Same-cycle vs edge and de.** The vs edge has priority; that de cycle is counted as x=0, y=0 of the new frame.
- **Error pulses.** Each error pulse lasts one cycle and has no effect on the schedule.

## Timing
- **Reset values.** O_rd_req=0, O_x=0, O_y=0, O_sel=0, O_sel_vld=0, O_frame_start=0, O_line_err=0, O_frame_err=0. State = WAIT_VS. Shift register cleared.
- **Request latency.** O_rd_req, O_x and O_y are registered, 1 cycle after the I_de sample they describe.
- **Select latency.** O_sel and O_sel_vld lag O_rd_req by exactly LAT cycles, i.e. LAT+1 cycles after I_de. This matches the sync delay line when it is LAT+1 stages deep.
- **Flag latency.** O_frame_start, O_line_err and O_frame_err are registered, 1 cycle after the detected edge.
- **I_en changes.** A mid-frame change of I_en has no effect until the next vs rising edge.
- **Entering SKIP.** Entries already in the select shift register drain normally.
- **Reset mid-frame.** Everything is cleared immediately. The remainder of the frame is ignored until the next vs rising edge.

## Test plan
Parameters for all scenarios: H_ACT=8, V_ACT=4, LAT=6.
- **Nominal frame.** Reset, I_en=1, vs pulse, then 4 lines of 8 de cycles. Required response:
  - O_rd_req is 0001 for x0-3 and 0010 for x4-7 on lines 0-1, then 0100/1000 on lines 2-3.
  - O_sel repeats the same quadrant sequence 6 cycles later.
  - No error pulses.
- **Disabled frame.** I_en=0 at the vs edge. Required response:
  - O_rd_req=0 and O_sel_vld=0 for the whole frame.
  - O_frame_start still pulses.
  - Setting I_en=1 mid-frame has no effect until the next vs.
- **Short line.** One line with 7 de cycles. Required response: O_line_err pulses once, 1 cycle after de falls; the next line starts at x=0.
- **Frame count error.** Only 3 lines before vs. Required response: O_frame_err pulses once; no pulse on the first vs after reset.
- **Simultaneous vs rising edge and de.** Required response: the first request is O_rd_req=0001 with x=0, y=0.
- **Reset mid-frame.** Assert reset at line 2. Required response:
  - All outputs 0 and pending O_sel_vld entries flushed.
  - De ignored until the next vs; the following frame is correct.
